// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Shares one variable-latency memory port between instruction fetch and the MEM stage.
// Define ARB_TIMEOUT_EN to abort accesses whose mem_ready does not arrive within TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("mem_port_arbiter: TIMEOUT must be at least 2");
    end

    logic [1:0]        state;
    logic              last_grant;
    logic              in_access;
    logic              timeout_hit;
    logic [DATA_W-1:0] cap_data;

    assign in_access = (state == FETCH) || (state == DATA);

    // Stores and aborted accesses hand back zero rather than whatever is on the bus.
    assign cap_data = (mem_ready && !mem_we) ? mem_rdata : '0;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign timeout_hit = in_access && !mem_ready && (wait_cnt == CNT_LAST);

    // Every grant leaves IDLE, so clearing in IDLE is clearing on grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if (in_access && !mem_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= GRANT_FETCH;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Data wins unless fetch is also waiting and data had the last turn.
                    if (d_req && (!if_req || last_grant != GRANT_DATA)) begin
                        state     <= DATA;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (if_req) begin
                        state    <= FETCH;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end
                end
                FETCH, DATA: begin
                    if (mem_ready || timeout_hit) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        last_grant <= (state == DATA);
                        if (state == DATA) begin
                            d_rdata <= cap_data;
                        end else begin
                            if_rdata <= cap_data;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // last_grant already names the winner once RESP is entered.
    assign if_ack = (state == RESP) && (last_grant == GRANT_FETCH);
    assign d_ack  = (state == RESP) && (last_grant == GRANT_DATA);

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbitration rules and a behavioural memory.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mem_store [logic [31:0]];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b0;
        if_req    = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b0; if_req = 1'b0; d_req = 1'b1; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
        #12;
        n_cmp++;
        if ({mem_req, mem_we, if_ack, d_ack, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 00000", {mem_req, mem_we, if_ack, d_ack, err});
        end
        n_cmp++;
        if ((mem_addr | mem_wdata | if_rdata | d_rdata) !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h %h %h %h want 0", mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        n_cmp++;
        if ({stall_if, stall_mem} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_stall got %b want 01", {stall_if, stall_mem});
        end
        do_reset();
    endtask

    task automatic test_fetch_zero_wait;
        if_addr = 32'h40; if_req = 1'b1;
        #1;
        n_cmp++;
        if (stall_if !== 1'b1) begin
            n_fail++; $display("FAIL fetch_stall_c0 got %b want 1", stall_if);
        end
        tick();
        n_cmp++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
            n_fail++;
            $display("FAIL fetch_grant got req=%b we=%b addr=%h want 1 0 00000040", mem_req, mem_we, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'hE3A0_0001;
        tick();
        mem_ready = 1'b0;
        n_cmp++;
        if ({if_ack, d_ack, stall_if, if_rdata} !== {1'b1, 1'b0, 1'b0, 32'hE3A0_0001}) begin
            n_fail++;
            $display("FAIL fetch_ack got ack=%b dack=%b stall=%b rdata=%h want 1 0 0 e3a00001",
                     if_ack, d_ack, stall_if, if_rdata);
        end
        tick();
        if_req = 1'b0;
        n_cmp++;
        if ({if_ack, mem_req} !== 2'b00) begin
            n_fail++; $display("FAIL fetch_idle got ack=%b req=%b want 0 0", if_ack, mem_req);
        end
    endtask

    task automatic test_timeout;
        int held;
        int err_seen;
        held = 0; err_seen = 0;
        if_addr = 32'h80; if_req = 1'b1; mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        tick();
`ifdef ARB_TIMEOUT_EN
        while (mem_req && held < 20) begin
            held++;
            if (stall_if !== 1'b1) err_seen++;
            tick();
        end
        n_cmp++;
        if (held !== 4) begin
            n_fail++; $display("FAIL timeout_len got %0d want 4", held);
        end
        n_cmp++;
        if ({if_ack, err, if_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL timeout_resp got ack=%b err=%b rdata=%h want 1 1 0", if_ack, err, if_rdata);
        end
        n_cmp++;
        if (err_seen !== 0) begin
            n_fail++; $display("FAIL timeout_stall got %0d drops want 0", err_seen);
        end
        tick();
        if_req = 1'b0;
        n_cmp++;
        if ({err, if_ack} !== 2'b00) begin
            n_fail++; $display("FAIL timeout_err_clear got err=%b ack=%b want 0 0", err, if_ack);
        end
`else
        while (mem_req && held < 60) begin
            held++;
            if (err !== 1'b0) err_seen++;
            tick();
        end
        n_cmp++;
        if (held !== 60) begin
            n_fail++; $display("FAIL no_timeout_len got %0d want 60", held);
        end
        n_cmp++;
        if (err_seen !== 0) begin
            n_fail++; $display("FAIL no_timeout_err got %0d cycles with err want 0", err_seen);
        end
        mem_ready = 1'b1; mem_rdata = 32'h55;
        tick();
        mem_ready = 1'b0;
        n_cmp++;
        if ({if_ack, err, if_rdata} !== {1'b1, 1'b0, 32'h55}) begin
            n_fail++;
            $display("FAIL late_ready_resp got ack=%b err=%b rdata=%h want 1 0 55", if_ack, err, if_rdata);
        end
        tick();
        if_req = 1'b0;
`endif
    endtask

    task automatic test_store_waits;
        int bad;
        bad = 0;
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1; mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if ({mem_req, mem_we, mem_addr, mem_wdata, stall_mem} !==
                {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1}) bad++;
            if (i == 3) begin
                mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
            end
            tick();
        end
        mem_ready = 1'b0;
        n_cmp++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL store_hold got %0d unstable cycles want 0", bad);
        end
        n_cmp++;
        if ({d_ack, if_ack, mem_req, mem_we, stall_mem, d_rdata} !== {5'b10000, 32'h0}) begin
            n_fail++;
            $display("FAIL store_ack got dack=%b iack=%b req=%b we=%b stall=%b rdata=%h want 1 0 0 0 0 0",
                     d_ack, if_ack, mem_req, mem_we, stall_mem, d_rdata);
        end
        tick();
        d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic test_reset_mid_access;
        d_we = 1'b0; d_addr = 32'h10; d_req = 1'b1;
        tick();
        n_cmp++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h10}) begin
            n_fail++; $display("FAIL midrst_grant got req=%b addr=%h want 1 10", mem_req, mem_addr);
        end
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req, mem_we, if_ack, d_ack, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL midrst_ctrl got %b want 00000", {mem_req, mem_we, if_ack, d_ack, err});
        end
        n_cmp++;
        if ((mem_addr | mem_wdata | if_rdata | d_rdata) !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_data got %h %h %h %h want 0", mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        if_addr = 32'h20; if_req = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h10}) begin
            n_fail++; $display("FAIL midrst_first_grant got req=%b addr=%h want 1 10", mem_req, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'h77;
        tick();
        mem_ready = 1'b0;
        n_cmp++;
        if ({d_ack, if_ack, d_rdata} !== {2'b10, 32'h77}) begin
            n_fail++;
            $display("FAIL midrst_ack got dack=%b iack=%b rdata=%h want 1 0 77", d_ack, if_ack, d_rdata);
        end
        tick();
        d_req = 1'b0; if_req = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [3:0] got;
        int gcyc [4];
        int ngr;
        int bad_gap;
        logic prev_req;
        do_reset();
        got = 4'b0; ngr = 0; prev_req = 1'b0; bad_gap = 0;
        if_addr = 32'h200; d_addr = 32'h300; d_we = 1'b0; if_req = 1'b1; d_req = 1'b1;
        for (int c = 1; c < 60 && ngr < 4; c++) begin
            tick();
            if (mem_req && !prev_req) begin
                got[3-ngr] = (mem_addr == 32'h300);
                gcyc[ngr]  = c;
                ngr++;
            end
            prev_req = mem_req;
            n_cmp++;
            if (if_ack && d_ack) begin
                n_fail++; $display("FAIL b2b_overlap got both acks in cycle %0d want one", c);
            end
            if (if_ack) begin
                n_cmp++;
                if (if_rdata !== ~32'h200) begin
                    n_fail++; $display("FAIL b2b_if_rdata got %h want %h", if_rdata, ~32'h200);
                end
            end
            if (d_ack) begin
                n_cmp++;
                if (d_rdata !== ~32'h300) begin
                    n_fail++; $display("FAIL b2b_d_rdata got %h want %h", d_rdata, ~32'h300);
                end
            end
            mem_ready = mem_req;
            mem_rdata = ~mem_addr;
        end
        mem_ready = 1'b0; if_req = 1'b0; d_req = 1'b0;
        for (int i = 1; i < ngr; i++) if (gcyc[i] - gcyc[i-1] != 3) bad_gap++;
        n_cmp++;
        if (ngr !== 4 || got !== 4'b1010) begin
            n_fail++; $display("FAIL b2b_order got %0d grants pattern %b want 4 grants 1010", ngr, got);
        end
        n_cmp++;
        if (bad_gap !== 0) begin
            n_fail++; $display("FAIL b2b_spacing got %0d gaps not 3 cycles want 0", bad_gap);
        end
    endtask

    task automatic test_random;
        int          phase;
        logic        win_d, last_d;
        logic        exp_req, exp_we, exp_fa, exp_da;
        logic [31:0] exp_addr, exp_wdata, exp_rdata;
        logic        f_ack_prev, d_ack_prev;
        int          wt;
        do_reset();
        phase = 0; last_d = 1'b0; win_d = 1'b0;
        exp_req = 1'b0; exp_we = 1'b0; exp_fa = 1'b0; exp_da = 1'b0;
        exp_addr = 32'h0; exp_wdata = 32'h0; exp_rdata = 32'h0;
        f_ack_prev = 1'b0; d_ack_prev = 1'b0; wt = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc != 0) tick();
            n_cmp++;
            if (mem_req !== exp_req) begin
                n_fail++; $display("FAIL rnd_mem_req cyc %0d got %b want %b", cyc, mem_req, exp_req);
            end
            if (exp_req) begin
                n_cmp++;
                if (mem_we !== exp_we || mem_addr !== exp_addr || (exp_we && mem_wdata !== exp_wdata)) begin
                    n_fail++;
                    $display("FAIL rnd_operands cyc %0d got we=%b addr=%h wdata=%h want %b %h %h",
                             cyc, mem_we, mem_addr, mem_wdata, exp_we, exp_addr, exp_wdata);
                end
            end
            n_cmp++;
            if ({if_ack, d_ack, err} !== {exp_fa, exp_da, 1'b0}) begin
                n_fail++;
                $display("FAIL rnd_acks cyc %0d got if=%b d=%b err=%b want %b %b 0",
                         cyc, if_ack, d_ack, err, exp_fa, exp_da);
            end
            if (exp_fa) begin
                n_cmp++;
                if (if_rdata !== exp_rdata) begin
                    n_fail++; $display("FAIL rnd_if_rdata cyc %0d got %h want %h", cyc, if_rdata, exp_rdata);
                end
            end
            if (exp_da) begin
                n_cmp++;
                if (d_rdata !== exp_rdata) begin
                    n_fail++; $display("FAIL rnd_d_rdata cyc %0d got %h want %h", cyc, d_rdata, exp_rdata);
                end
            end

            // Requesters: hold until ack, then drop or issue a fresh request the cycle after.
            if (f_ack_prev) begin
                if_req = 1'($urandom_range(0, 1)); if_addr = 32'($urandom_range(0, 15)) * 4;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = 32'($urandom_range(0, 15)) * 4;
            end
            if (d_ack_prev || (!d_req && $urandom_range(0, 2) == 0)) begin
                d_req   = d_ack_prev ? 1'($urandom_range(0, 1)) : 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
                d_wdata = $urandom;
            end

            // Memory: at most two wait states, with stray ready pulses while idle.
            if (mem_req) begin
                mem_ready = (wt >= 2) || ($urandom_range(0, 2) == 0);
                wt = mem_ready ? 0 : wt + 1;
            end else begin
                mem_ready = ($urandom_range(0, 3) == 0);
                wt = 0;
            end
            mem_rdata = (mem_req && !mem_we) ? mem_read(mem_addr) : $urandom;
            if (mem_req && mem_ready && mem_we) mem_store[mem_addr] = mem_wdata;

            #1;
            n_cmp++;
            if (stall_if !== (if_req && !exp_fa) || stall_mem !== (d_req && !exp_da)) begin
                n_fail++;
                $display("FAIL rnd_stall cyc %0d got %b%b want %b%b", cyc, stall_if, stall_mem,
                         if_req && !exp_fa, d_req && !exp_da);
            end

            f_ack_prev = exp_fa;
            d_ack_prev = exp_da;
            exp_fa = 1'b0;
            exp_da = 1'b0;
            case (phase)
                0: if (if_req || d_req) begin
                    win_d     = d_req && (!if_req || !last_d);
                    exp_req   = 1'b1;
                    exp_we    = win_d ? d_we : 1'b0;
                    exp_addr  = win_d ? d_addr : if_addr;
                    exp_wdata = d_wdata;
                    phase     = 1;
                end
                1: if (mem_ready) begin
                    exp_req   = 1'b0;
                    exp_rdata = exp_we ? 32'h0 : mem_read(exp_addr);
                    exp_fa    = !win_d;
                    exp_da    = win_d;
                    last_d    = win_d;
                    phase     = 2;
                end
                default: phase = 0;
            endcase
        end
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_zero_wait();
        test_timeout();
        test_store_waits();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences a single shared memory port between the instruction fetch stage and the MEM stage of the 5-stage pipeline, so instruction and data accesses can target one unified, variable-latency memory. The block grants one requester at a time, drives the memory request/ready handshake, registers the read data back to the winner, and supplies stall signals that freeze the pipeline while an access is outstanding.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max cycles waiting for mem_ready (used only with ARB_TIMEOUT_EN); must be ≥2
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_rdata  out  DATA_W  fetched instruction; valid while if_ack
- if_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request from MEM stage; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid while d_ack
- d_ack  out  1  one-cycle completion pulse for data
- stall_if  out  1  if_req & ~if_ack (combinational)
- stall_mem  out  1  d_req & ~d_ack (combinational)
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes the access this cycle
- err  out  1  access timed out; valid with the ack pulse

## Operation
- FSM states: IDLE, FETCH, DATA, RESP.
- IDLE: if d_req and (~if_req or last_grant≠DATA) → DATA; else if if_req → FETCH; else stay. Resulting arbitration: data has priority, but when both are pending and the previous grant was DATA, fetch wins (no starvation). last_grant resets to FETCH.
- On grant: latch the winner's addr into mem_addr; for DATA, also latch d_we into mem_we and d_wdata into mem_wdata; set mem_req=1. FETCH forces mem_we=0.
- FETCH/DATA: hold mem_req, mem_we, mem_addr, mem_wdata stable until mem_ready=1. On mem_ready: capture mem_rdata into the winner's rdata register (stores capture 0), clear mem_req, clear mem_we, update last_grant, → RESP.
- RESP: the winner's ack is 1 for exactly this cycle; the non-winner's ack stays 0. Requests sampled in RESP are ignored. → IDLE.
- The requester must deassert req, or present a new request, in the cycle after ack.
- The rdata registers hold their value until the next capture.
- mem_ready outside FETCH/DATA is ignored.
- Asynchronous reset asserted mid-access: immediately go to IDLE; mem_req, mem_we, acks and err = 0; addr, wdata, rdata registers = 0; the in-flight access is abandoned.

## Timing
- Reset values: all outputs 0, except stall_if and stall_mem, which follow their inputs combinationally.
- Zero-wait memory: req sampled at end of cycle 0 → mem_req=1 in cycle 1 with mem_ready=1 → ack in cycle 2 → IDLE in cycle 3. Minimum 3 cycles per access; back-to-back throughput is one access per 3 cycles.
- Each wait cycle of mem_ready adds one cycle.
- Stalls drop in the ack cycle, so the pipeline advances on the edge that ends that cycle.

## Configuration
- ARB_TIMEOUT_EN defined: a counter clears on grant and increments each cycle in FETCH or DATA without mem_ready. When the count reaches TIMEOUT-1 without mem_ready: clear mem_req, force the winner's rdata to 0, set err=1, → RESP. err is 1 only during that RESP cycle.
- ARB_TIMEOUT_EN undefined: the block waits indefinitely; no counter is present; err is tied to 0.

## Test plan
- Fetch only, zero-wait memory, if_addr=0x40, mem_rdata=0xE3A00001 → mem_req in cycle 1 with mem_addr=0x40 and mem_we=0; if_ack and if_rdata=0xE3A00001 in cycle 2.
- Store, d_addr=0x100, d_wdata=0xDEADBEEF, 3 wait cycles → mem_we=1 and the operands held stable for 4 cycles; d_ack after the mem_ready cycle; d_rdata=0.
- if_req and d_req both held continuously → grants alternate DATA, FETCH, DATA, FETCH; acks never overlap.
- reset pulled low while in DATA with 2 wait cycles elapsed → mem_req=0 immediately; after release, FSM in IDLE and the next grant is DATA (last_grant reset).
- ARB_TIMEOUT_EN defined, TIMEOUT=4, mem_ready never asserted → mem_req drops after 4 cycles; ack with err=1 and rdata=0.
- Without the macro, same stimulus → mem_req held for 50 or more cycles; err stays 0.
